// File: rtl/ball_miss_detector.sv
// Per-frame ball/paddle collision judge: hit and miss pulses, respawn cooldown and respawn handshake.
// One cycle from the frame_tick evaluation to the pulse; respawn_req stays high until respawn_ack is seen.
module ball_miss_detector #(
    parameter int X_W            = 8,
    parameter int Y_W            = 7,
    parameter int PADDLE_Y       = 112,
    parameter int PADDLE_W       = 20,
    parameter int SCREEN_BOTTOM  = 119,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic           game_active,
    input  logic [X_W-1:0] ball_x,
    input  logic [Y_W-1:0] ball_y,
    input  logic           ball_down,
    input  logic [X_W-1:0] paddle_x,
    input  logic           respawn_ack,
    output logic           lost_health,
    output logic           paddle_hit,
    output logic           respawn_req,
    output logic [7:0]     miss_count
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] TRACK    = 3'd1;
    localparam logic [2:0] MISS     = 3'd2;
    localparam logic [2:0] COOLDOWN = 3'd3;
    localparam logic [2:0] REQ      = 3'd4;

    localparam logic [Y_W-1:0] HIT_ROW    = Y_W'(PADDLE_Y - 1);
    localparam logic [Y_W-1:0] BOTTOM_ROW = Y_W'(SCREEN_BOTTOM);
    localparam logic [X_W:0]   PAD_SPAN   = (X_W + 1)'(PADDLE_W - 1);
    localparam logic [7:0]     COOL_LOAD  = 8'(RESPAWN_FRAMES);

    logic [2:0]     state, state_nxt;
    logic [7:0]     cool_cnt, cool_nxt;
    logic [7:0]     miss_nxt;
    logic           lost_nxt, hit_nxt, req_nxt;
    logic [X_W:0]   paddle_right;
    logic           hit_now, miss_now;

    // Right edge carries an extra bit so a paddle near x=255 cannot wrap to a small value.
    assign paddle_right = {1'b0, paddle_x} + PAD_SPAN;
    assign hit_now      = ball_down && (ball_y == HIT_ROW) &&
                          (ball_x >= paddle_x) && ({1'b0, ball_x} <= paddle_right);
    assign miss_now     = (ball_y >= BOTTOM_ROW);

    always_comb begin
        state_nxt = state;
        cool_nxt  = cool_cnt;
        miss_nxt  = miss_count;
        lost_nxt  = 1'b0;
        hit_nxt   = 1'b0;
        req_nxt   = 1'b0;
        if (!game_active) begin
            state_nxt = IDLE;
            cool_nxt  = '0;
        end else begin
            case (state)
                IDLE: state_nxt = TRACK;
                TRACK: begin
                    if (frame_tick) begin
                        if (hit_now) begin
                            hit_nxt = 1'b1;
                        end else if (miss_now) begin
                            state_nxt = MISS;
                            lost_nxt  = 1'b1;
                            miss_nxt  = (miss_count == 8'hFF) ? miss_count : miss_count + 8'd1;
                            cool_nxt  = COOL_LOAD;
                        end
                    end
                end
                // Ticks during MISS are ignored so the freshly loaded count is not shortened.
                MISS: state_nxt = COOLDOWN;
                COOLDOWN: begin
                    if (cool_cnt == 8'd0) begin
                        state_nxt = REQ;
                        req_nxt   = 1'b1;
                    end else if (frame_tick) begin
                        cool_nxt = cool_cnt - 8'd1;
                        if (cool_cnt == 8'd1) begin
                            state_nxt = REQ;
                            req_nxt   = 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (respawn_req && respawn_ack) begin
                        state_nxt = TRACK;
                    end else begin
                        req_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cool_cnt    <= '0;
            miss_count  <= '0;
            lost_health <= 1'b0;
            paddle_hit  <= 1'b0;
            respawn_req <= 1'b0;
        end else begin
            state       <= state_nxt;
            cool_cnt    <= cool_nxt;
            miss_count  <= miss_nxt;
            lost_health <= lost_nxt;
            paddle_hit  <= hit_nxt;
            respawn_req <= req_nxt;
        end
    end

endmodule

// File: tb/tb_ball_miss_detector.sv
// Directed bench: cycle table for hit/miss/respawn, then hand sequences for abort, edges, saturation, reset.
module tb_ball_miss_detector;

    logic       clk = 1'b0;
    logic       reset, frame_tick, game_active, ball_down, respawn_ack;
    logic [7:0] ball_x, paddle_x;
    logic [6:0] ball_y;
    logic       lost_health, paddle_hit, respawn_req;
    logic [7:0] miss_count;

    int n_vec = 0;
    int n_bad = 0;

    ball_miss_detector #(.RESPAWN_FRAMES(3)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_active(game_active),
        .ball_x(ball_x), .ball_y(ball_y), .ball_down(ball_down), .paddle_x(paddle_x),
        .respawn_ack(respawn_ack), .lost_health(lost_health), .paddle_hit(paddle_hit),
        .respawn_req(respawn_req), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ft, ga, bd, ack;
        logic [7:0] bx, px;
        logic [6:0] by;
        logic       lost, hit, req;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ft, input logic [7:0] bx, input logic [6:0] by, input logic bd,
                       input logic ack, input logic lost, input logic hit, input logic req,
                       input logic [7:0] cnt);
        vec_t v;
        v.ft = ft; v.ga = 1'b1; v.bd = bd; v.ack = ack; v.bx = bx; v.px = 8'd50; v.by = by;
        v.lost = lost; v.hit = hit; v.req = req; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full miss/respawn round from TRACK, ball held at the bottom, ticks every 4 cycles.
    task automatic miss_round(output int lost_seen, output bit acked);
        lost_seen = 0;
        acked     = 1'b0;
        ball_y    = 7'd119;
        ball_down = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (respawn_req) begin
                frame_tick  = 1'b0;
                respawn_ack = 1'b1;
                step();
                respawn_ack = 1'b0;
                acked       = 1'b1;
                break;
            end
            frame_tick = (k % 4 == 0);
            step();
            if (lost_health) lost_seen++;
        end
        frame_tick = 1'b0;
        ball_y     = 7'd50;
    endtask

    initial begin
        int  lost_seen, lost_total, acked_total;
        bit  acked;

        reset = 1'b1; frame_tick = 1'b0; game_active = 1'b0; ball_down = 1'b1;
        respawn_ack = 1'b0; ball_x = 8'd50; paddle_x = 8'd50; ball_y = 7'd50;

        //   ft  bx   by  bd ack  lost hit req cnt
        add(0, 50,  50, 1, 0,   0, 0, 0, 0);   // IDLE -> TRACK
        add(1, 50, 111, 1, 0,   0, 1, 0, 0);   // left edge hit
        add(0, 50, 111, 1, 0,   0, 0, 0, 0);   // pulse is one cycle
        add(1, 69, 111, 1, 0,   0, 1, 0, 0);   // right edge hit
        add(1, 70, 111, 1, 0,   0, 0, 0, 0);   // one past right edge
        add(1, 49, 111, 1, 0,   0, 0, 0, 0);   // one before left edge
        add(1, 60, 111, 0, 0,   0, 0, 0, 0);   // moving up: no hit
        add(1, 60, 119, 1, 0,   1, 0, 0, 1);   // miss
        add(1, 60, 119, 1, 0,   0, 0, 0, 1);   // MISS cycle tick ignored
        add(1, 60, 119, 1, 0,   0, 0, 0, 1);   // cooldown 3 -> 2
        add(0, 60, 119, 1, 0,   0, 0, 0, 1);
        add(1, 60, 119, 1, 0,   0, 0, 0, 1);   // 2 -> 1
        add(1, 60, 119, 1, 1,   0, 0, 1, 1);   // 1 -> 0, REQ; ack before req ignored
        add(1, 60, 119, 1, 0,   0, 0, 1, 1);   // REQ ignores the ball
        add(0, 60,  50, 1, 1,   0, 0, 0, 1);   // ack -> TRACK
        add(0, 60,  50, 1, 1,   0, 0, 0, 1);   // stray ack in TRACK
        add(1,  0, 119, 1, 0,   1, 0, 0, 2);   // second miss

        step(); step();
        chk("reset_lost", lost_health, 0);
        chk("reset_hit",  paddle_hit,  0);
        chk("reset_req",  respawn_req, 0);
        chk("reset_cnt",  miss_count,  0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            frame_tick = tbl[i].ft; game_active = tbl[i].ga; ball_x = tbl[i].bx;
            ball_y = tbl[i].by; ball_down = tbl[i].bd; paddle_x = tbl[i].px;
            respawn_ack = tbl[i].ack;
            step();
            chk($sformatf("row%0d_lost", i), lost_health, tbl[i].lost);
            chk($sformatf("row%0d_hit",  i), paddle_hit,  tbl[i].hit);
            chk($sformatf("row%0d_req",  i), respawn_req, tbl[i].req);
            chk($sformatf("row%0d_cnt",  i), miss_count,  tbl[i].cnt);
        end
        frame_tick = 1'b0; respawn_ack = 1'b0; ball_y = 7'd50;

        // Abort during cooldown
        step();                      // MISS -> COOLDOWN
        frame_tick = 1'b1; step();   // 3 -> 2
        frame_tick = 1'b0; game_active = 1'b0; step();
        chk("abort_lost", lost_health, 0);
        chk("abort_hit",  paddle_hit,  0);
        chk("abort_req",  respawn_req, 0);
        chk("abort_cnt",  miss_count,  2);
        game_active = 1'b1; step();  // IDLE -> TRACK

        // Paddle at the screen edge and beyond 8-bit wrap
        ball_down = 1'b1; ball_y = 7'd111; frame_tick = 1'b1;
        paddle_x = 8'd150; ball_x = 8'd159; step(); chk("edge150_x159", paddle_hit, 1);
        ball_x = 8'd3;                      step(); chk("edge150_x3",   paddle_hit, 0);
        paddle_x = 8'd245;                  step(); chk("wrap245_x3",   paddle_hit, 0);
        ball_x = 8'd255;                    step(); chk("wrap245_x255", paddle_hit, 1);
        chk("edge_no_lost", lost_health, 0);
        frame_tick = 1'b0; ball_y = 7'd50; paddle_x = 8'd50; step();

        // One miss held through cooldown and REQ counts once
        miss_round(lost_seen, acked);
        chk("dbl_lost_pulses", lost_seen, 1);
        chk("dbl_acked", acked, 1);
        chk("dbl_cnt", miss_count, 3);
        chk("dbl_req_low", respawn_req, 0);

        lost_total = 0; acked_total = 0;
        for (int r = 0; r < 297; r++) begin
            miss_round(lost_seen, acked);
            lost_total  += lost_seen;
            acked_total += int'(acked);
        end
        chk("sat_lost_total", lost_total, 297);
        chk("sat_acked_total", acked_total, 297);
        chk("sat_cnt", miss_count, 255);

        // Reset while in REQ
        ball_y = 7'd119; ball_down = 1'b0;
        for (int k = 0; k < 100; k++) begin
            frame_tick = (k % 4 == 0);
            step();
            if (respawn_req) break;
        end
        frame_tick = 1'b0;
        chk("pre_reset_req", respawn_req, 1);
        reset = 1'b1; step();
        chk("rst_req", respawn_req, 0);
        chk("rst_cnt", miss_count, 0);
        chk("rst_lost", lost_health, 0);
        reset = 1'b0; game_active = 1'b0; step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ball_miss_detector.md
Name: ball_miss_detector

Overview:
- Per-frame collision judge between the ball and the bottom of the playfield.
- Sits directly upstream of the health/loss checker, which consumes the one-cycle lost_health pulse.
- Also issues paddle-bounce pulses to the ball controller and runs the post-miss respawn cooldown and respawn handshake.
- Evaluates once per frame_tick, the strobe that marks a freshly updated ball position.

Parameters:
- X_W, 8, width of x coordinates (160-wide screen).
- Y_W, 7, width of y coordinates (120-tall screen).
- PADDLE_Y, 112, paddle row. The ball collides when it sits at row PADDLE_Y-1.
- PADDLE_W, 20, paddle width in pixels.
- SCREEN_BOTTOM, 119, last visible row. A ball y >= this is a miss.
- RESPAWN_FRAMES, 60, frame_ticks to wait after a miss before requesting respawn. Width is 8 bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle strobe; ball_x/ball_y are valid and stable in this cycle.
- game_active  in  1  high while a round is in play, from the game FSM.
- ball_x  in  X_W  ball x position.
- ball_y  in  Y_W  ball y position.
- ball_down  in  1  1 = ball currently moving downward.
- paddle_x  in  X_W  paddle left edge.
- respawn_ack  in  1  ball controller has re-served the ball.
- lost_health  out  1  one-cycle pulse per miss.
- paddle_hit  out  1  one-cycle pulse; ball must reverse its y direction.
- respawn_req  out  1  level; held until respawn_ack.
- miss_count  out  8  total misses since reset, saturating.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, lost_health 0, paddle_hit 0, respawn_req 0, miss_count 0, cooldown counter 0.
- States are IDLE, TRACK, MISS, COOLDOWN and REQ.

State transitions:
- IDLE -> TRACK when game_active=1.
- From any state, game_active=0 -> IDLE on the next cycle. lost_health, paddle_hit and respawn_req go to 0; miss_count holds.
- TRACK: frame_tick is sampled in cycle N.
  - Hit: ball_down=1, ball_y==PADDLE_Y-1 and paddle_x <= ball_x <= paddle_x+PADDLE_W-1. Then paddle_hit=1 in cycle N+1 only, and the state stays TRACK.
  - Miss: otherwise, if ball_y >= SCREEN_BOTTOM, the state becomes MISS in N+1.
  - Neither: no action.
  - frame_tick=0: no evaluation.
- MISS (exactly one cycle):
  - lost_health=1.
  - miss_count increments, saturating at 255.
  - Cooldown counter loads RESPAWN_FRAMES.
  - Next state COOLDOWN.
- COOLDOWN:
  - If the counter is 0, go to REQ on the next cycle.
  - Otherwise decrement on each frame_tick.
  - With RESPAWN_FRAMES=0, MISS -> COOLDOWN -> REQ takes consecutive cycles.
- REQ:
  - respawn_req=1 from state entry.
  - respawn_ack is sampled only while respawn_req=1. On ack, respawn_req goes to 0 on the next cycle and the state returns to TRACK.
  - respawn_ack in any other state is ignored.

Arithmetic:
- The paddle right edge is computed in X_W+1 bits, so paddle_x near the screen edge cannot wrap.
- The x range check is inclusive at both ends.

Boundary and ordering rules:
- The hit check takes priority over the miss check within the same evaluation.
- Ball and paddle activity in MISS, COOLDOWN and REQ is ignored, so at most one lost_health is produced per miss.
- frame_tick arriving together with the MISS cycle does not decrement the freshly loaded counter.
- Reset in any state, including mid-cooldown or mid-REQ, returns to reset values on the next cycle.

Test Plan:
1. Paddle hit: paddle_x=50, ball_x=50 then 69, ball_y=111, ball_down=1, frame_tick -> paddle_hit high exactly one cycle after each tick. Repeat with ball_x=70 and ball_x=49 -> no paddle_hit and no miss.
2. Miss path: ball_y=119, frame_tick, RESPAWN_FRAMES=3 -> lost_health one cycle at N+1 and miss_count=1. respawn_req rises one cycle after the 3rd subsequent frame_tick. respawn_ack -> respawn_req low next cycle, state TRACK.
3. No double count: hold ball_y=119 with frame_tick every 4 cycles through COOLDOWN and REQ -> exactly one lost_health and miss_count=1. A second miss after respawn -> miss_count=2.
4. Saturation and edges: 300 misses with RESPAWN_FRAMES=0 -> miss_count=255. paddle_x=150, ball_x=159 at row 111 -> paddle_hit, with no wrap false-hit at ball_x=3.
5. Abort and reset: game_active drops during COOLDOWN -> IDLE with all pulses and respawn_req 0 and miss_count kept. reset asserted in REQ -> respawn_req 0 and miss_count 0 next cycle. Stray respawn_ack in TRACK -> no effect.
